// File: rtl/sd_fifo_pkg.sv
// Shared helpers for the sd_fifo family: pointer arithmetic for occupancy and
// full/empty detection. Pointers are passed zero-extended to PtrMaxW bits so
// one set of functions serves every depth; callers size-cast the results.
package sd_fifo_pkg;

  localparam int unsigned PtrMaxW = 32;

  typedef logic [PtrMaxW-1:0] ptr_t;

  // Occupancy from wrap-bit pointers; masking to asz+1 bits gives the
  // modulo-2*depth difference.
  function automatic ptr_t ptr_usage(ptr_t wr, ptr_t rd, int unsigned asz);
    ptr_t mask;
    mask = (ptr_t'(1) << (asz + 1)) - ptr_t'(1);
    return (wr - rd) & mask;
  endfunction

  // Pointers identical, including the wrap bit.
  function automatic logic ptr_empty(ptr_t wr, ptr_t rd);
    return wr == rd;
  endfunction

  // Index bits equal and only the wrap bit differs.
  function automatic logic ptr_full(ptr_t wr, ptr_t rd, int unsigned asz);
    return (wr ^ rd) == (ptr_t'(1) << asz);
  endfunction

endpackage

// File: rtl/sd_fifo_hwm.sv
// High-water mark register for sd_fifo_count: tracks the peak registered
// occupancy since reset; a clear pulse reloads it with the current occupancy.
module sd_fifo_hwm #(
  parameter int unsigned asz = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hwm_clr_i,
  input  logic [asz:0] usage_i,
  output logic [asz:0] hwm_o
);

  logic [asz:0] hwm_q, hwm_d;

  // Next peak: clear wins, otherwise keep the larger of peak and occupancy.
  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr_i) begin
      hwm_d = usage_i;
    end else if (usage_i > hwm_q) begin
      hwm_d = usage_i;
    end
  end

  // Peak register, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm_o = hwm_q;

endmodule

// File: rtl/sd_fifo_count.sv
// srdy/drdy FIFO with registered occupancy output. State lives entirely in
// the wrap-bit read/write pointers; no bypass path from c_ to p_.
// Optional feature: define SD_FIFO_COUNT_HWM_EN to add the hwm/hwm_clr
// high-water mark ports.
module sd_fifo_count
  import sd_fifo_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8,
  localparam int unsigned asz = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  output logic [asz:0]     usage
`ifdef SD_FIFO_COUNT_HWM_EN
  ,
  input  logic             hwm_clr,
  output logic [asz:0]     hwm
`endif
);

  localparam int unsigned PtrW = asz + 1;

  logic [width-1:0] mem_q [depth];
  logic [asz:0]     wrptr_q, wrptr_d;
  logic [asz:0]     rdptr_q, rdptr_d;
  logic [asz:0]     usage_q, usage_d;
  logic             full, empty;
  logic             wr_en, rd_en;

  assign full  = ptr_full(ptr_t'(wrptr_q), ptr_t'(rdptr_q), asz);
  assign empty = ptr_empty(ptr_t'(wrptr_q), ptr_t'(rdptr_q));

  // Handshakes depend only on registered pointers, so there is no
  // combinational path p_drdy->c_drdy or c_srdy->p_srdy.
  assign c_drdy = ~full;
  assign p_srdy = ~empty;
  assign wr_en  = c_srdy & ~full;
  assign rd_en  = p_drdy & ~empty;

  // Pointer advance and occupancy computed from the next-state pointers.
  always_comb begin
    wrptr_d = wrptr_q + {{asz{1'b0}}, wr_en};
    rdptr_d = rdptr_q + {{asz{1'b0}}, rd_en};
    usage_d = PtrW'(ptr_usage(ptr_t'(wrptr_d), ptr_t'(rdptr_d), asz));
  end

  // Pointer and occupancy registers; reset discards all stored words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      usage_q <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      usage_q <= usage_d;
    end
  end

  // Storage array; contents are not reset, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wrptr_q[asz-1:0]] <= c_data;
    end
  end

  assign p_data = mem_q[rdptr_q[asz-1:0]];
  assign usage  = usage_q;

`ifdef SD_FIFO_COUNT_HWM_EN
  sd_fifo_hwm #(
    .asz (asz)
  ) u_hwm (
    .clk       (clk),
    .reset     (reset),
    .hwm_clr_i (hwm_clr),
    .usage_i   (usage_q),
    .hwm_o     (hwm)
  );
`endif

endmodule

// File: doc/sd_fifo_count.md
# sd_fifo_count

Synchronous srdy/drdy FIFO with occupancy reporting, placed directly downstream of any two-port srdy/drdy stage to absorb bursts from its p_ side. Consumes a word on the c_ interface, presents the oldest stored word on the p_ interface, and exposes an occupancy count for flow-control and debug. It obeys the codebase handshake contract on both sides:
- srdy held until drdy.
- Data held stable while srdy && !drdy.

## Interface
Parameters:
- width, 8, data word width in bits
- depth, 8, number of entries; power of two, >= 2
- asz, $clog2(depth), pointer index width (derived, not overridden)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- c_srdy  input  1  upstream word valid
- c_drdy  output  1  FIFO can accept a word this cycle
- c_data  input  width  upstream word
- p_srdy  output  1  FIFO holds a word for downstream
- p_drdy  input  1  downstream accepts the word this cycle
- p_data  output  width  oldest stored word
- usage  output  asz+1  current number of stored words, 0..depth

## Operation
- Storage: depth x width register array, write pointer wrptr and read pointer rdptr, each asz+1 bits.
  - Low asz bits index the array.
  - MSB is the wrap bit.
- Write: c_srdy && c_drdy stores c_data at wrptr[asz-1:0]; wrptr increments.
- Read: p_srdy && p_drdy retires the head entry; rdptr increments.
- Pointers wrap modulo 2*depth (natural asz+1 overflow).
- Empty: wrptr == rdptr.
- Full: low bits equal and MSBs differ.
- c_drdy = !full. No bypass: when full, a same-cycle read does not enable a write.
- p_srdy = !empty.
- p_data = array[rdptr[asz-1:0]]; held stable while p_srdy && !p_drdy, because the head entry is never overwritten while not full.
- usage = wrptr - rdptr (asz+1-bit unsigned subtraction, wraps correctly); registered value, updated with the pointers.
- Simultaneous write and read when neither full nor empty: both pointers advance; usage unchanged.
- Write when empty: the word becomes visible the next cycle; no same-cycle read of incoming data.
- c_data is ignored when c_srdy is low or c_drdy is low.

## Timing
- Reset values: wrptr=0, rdptr=0, usage=0, p_srdy=0, c_drdy=1.
  - p_data is don't-care after reset; array contents are not reset.
- Reset asserted mid-operation: all stored words are discarded immediately (asynchronous). Outputs take their reset values in the same cycle.
- Latency c_ to p_: 1 cycle. A word accepted at edge N has p_srdy=1 after edge N.
- Throughput: 1 word/cycle sustained when 0 < usage < depth.
- c_drdy falls the cycle after the write that fills the FIFO. It rises the cycle after the read that leaves it full.
- No combinational path from p_drdy to c_drdy or from c_srdy to p_srdy.

## Configuration
- SD_FIFO_COUNT_HWM_EN defined: adds output port hwm (asz+1 bits), the high-water mark.
  - Holds the maximum usage seen since reset; reset value 0.
  - Updated one cycle after usage: hwm <= max(hwm, usage).
  - Adds input hwm_clr (1 bit); when high, hwm loads the current usage.
- Macro not defined: hwm and hwm_clr ports are absent and no related logic exists. All other behaviour is identical.

## Structure
- Shared package sd_fifo_pkg holds:
  - function for the pointer-to-usage calculation;
  - localparam-style helpers for full/empty compare.
- One sub-module: sd_fifo_hwm.
  - Holds the high-water register and its clear logic.
  - Instantiated only under SD_FIFO_COUNT_HWM_EN.
- The fill and drain machines use no explicit FSM. State is fully encoded by the pointers.

## Test plan
- Reset, then single write 0xA5 with p_drdy=0 -> next cycle p_srdy=1, p_data=0xA5, usage=1. Data held until p_drdy=1; usage returns to 0 the following cycle.
- depth=8: write 8 words 0x00..0x07 with p_drdy=0 -> c_drdy=0 after 8th accept, usage=8. Drain returns 0x00..0x07 in order; p_srdy=0 after last.
- Full FIFO, c_srdy=1 and p_drdy=1 in the same cycle -> only the read occurs, usage=7. The write is accepted on the next cycle.
- Continuous streaming of 20 words with c_srdy=p_drdy=1 -> pointers wrap twice. Output sequence matches input, usage stays 1.
- Assert reset with usage=5 -> p_srdy=0, c_drdy=1, usage=0 immediately. No stale word appears after release.
- With SD_FIFO_COUNT_HWM_EN: fill to 6, drain to 2 -> hwm=6. Pulse hwm_clr -> hwm=2.
